// File: rtl/htif_tohost_monitor.sv
// HTIF tohost monitor: decodes exit and console-putchar writes, buffers console
// bytes in a FIFO drained over valid/ready, and acknowledges each byte via fromhost.
module htif_tohost_monitor #(
   parameter int XLEN       = 64,
   parameter int FIFO_DEPTH = 16,
   parameter int ACK_DELAY  = 1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            tohost_we,
   input  logic [XLEN-1:0] tohost,
   output logic            fromhost_we,
   output logic [XLEN-1:0] fromhost,
   output logic            con_valid,
   output logic [7:0]      con_data,
   input  logic            con_ready,
   output logic            done,
   output logic            pass,
   output logic [XLEN-2:0] exit_code,
   output logic            err
);

   localparam int FW = (XLEN == 64) ? 8 : 4;
   localparam int PW = XLEN - 2 * FW;
   localparam int EW = XLEN - 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [FW-1:0]   FIELD_ONE = FW'(1);
   localparam logic [XLEN-1:0] ACK_WORD  = {FIELD_ONE, FIELD_ONE, {PW{1'b0}}};
   localparam logic [AW:0]     PTR_ONE   = (AW + 1)'(1);

   typedef enum logic [1:0] {IDLE, PUSH, ACK, HALT} state_e;

   state_e          state_q;
   logic [7:0]      con_byte_q;
   logic [3:0]      cnt_q;
   logic            fromhost_we_q;
   logic [XLEN-1:0] fromhost_q;
   logic            done_q;
   logic            pass_q;
   logic [EW-1:0]   exit_code_q;
   logic            err_q;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]     rd_ptr_q, rd_ptr_d;

   logic [FW-1:0]   dev;
   logic [FW-1:0]   cmd;
   logic [PW-1:0]   payload;
   logic [EW-1:0]   exit_val;
   logic            is_exit;
   logic            is_con;
   logic            empty;
   logic            full;
   logic            pop;
   logic            push;

   assign dev      = tohost[XLEN-1 -: FW];
   assign cmd      = tohost[XLEN-FW-1 -: FW];
   assign payload  = tohost[PW-1:0];
   assign exit_val = EW'(payload[PW-1:1]);
   assign is_exit  = (dev == '0) && (cmd == '0) && payload[0];
   assign is_con   = (dev == FIELD_ONE) && (cmd == FIELD_ONE);

   // Same low bits with differing MSBs means the writer is a full lap ahead.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop   = !empty && con_ready;
   assign push  = (state_q == PUSH) && (!full || pop);

   assign con_valid   = !empty;
   assign con_data    = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
   assign fromhost_we = fromhost_we_q;
   assign fromhost    = fromhost_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign exit_code   = exit_code_q;
   assign err         = err_q;

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the reset pointers alone make its contents invisible.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= con_byte_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= IDLE;
         con_byte_q    <= '0;
         cnt_q         <= '0;
         fromhost_we_q <= 1'b0;
         fromhost_q    <= '0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         exit_code_q   <= '0;
         err_q         <= 1'b0;
      end else begin
         fromhost_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (tohost_we) begin
                  if (is_exit) begin
                     done_q      <= 1'b1;
                     pass_q      <= (exit_val == '0);
                     exit_code_q <= exit_val;
                     state_q     <= HALT;
                  end else if (is_con) begin
                     con_byte_q <= payload[7:0];
                     state_q    <= PUSH;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            PUSH: begin
               if (tohost_we) err_q <= 1'b1;
               if (push) begin
                  cnt_q   <= 4'(ACK_DELAY);
                  state_q <= ACK;
               end
            end
            ACK: begin
               if (tohost_we) err_q <= 1'b1;
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  fromhost_we_q <= 1'b1;
                  fromhost_q    <= ACK_WORD;
                  state_q       <= IDLE;
               end
            end
            HALT: begin
               state_q <= HALT;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_htif_tohost_monitor.sv
// Directed bench for htif_tohost_monitor: exit decode, console stream, back-pressure,
// protocol errors and mid-transaction reset, with hand-computed expectations.
module tb_htif_tohost_monitor;

   localparam int XLEN       = 64;
   localparam int FIFO_DEPTH = 16;
   localparam int ACK_DELAY  = 1;
   localparam logic [63:0] ACK_WORD = 64'h0101_0000_0000_0000;

   logic            CLK = 1'b0;
   logic            RST;
   logic            tohost_we;
   logic [63:0]     tohost;
   logic            fromhost_we;
   logic [63:0]     fromhost;
   logic            con_valid;
   logic [7:0]      con_data;
   logic            con_ready;
   logic            done;
   logic            pass;
   logic [62:0]     exit_code;
   logic            err;

   int          n_cmp = 0;
   int          n_err = 0;
   int          ack_cnt = 0;
   logic [7:0]  got_q [$];

   htif_tohost_monitor #(
      .XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH), .ACK_DELAY(ACK_DELAY)
   ) dut (
      .CLK(CLK), .RST(RST), .tohost_we(tohost_we), .tohost(tohost),
      .fromhost_we(fromhost_we), .fromhost(fromhost),
      .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
      .done(done), .pass(pass), .exit_code(exit_code), .err(err)
   );

   always #5 CLK = ~CLK;

   // Pre-edge values are read here, so each ack and each popped byte is seen once.
   always @(posedge CLK) begin
      if (fromhost_we) ack_cnt++;
      if (con_valid && con_ready) got_q.push_back(con_data);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      tohost_we = 1'b0;
      tohost = '0;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // Returns the number of cycles from strobe to ack, or -1 if none within budget.
   task automatic send_con(input logic [7:0] b, input int budget, output int lat);
      @(negedge CLK);
      tohost_we = 1'b1;
      tohost = {16'h0101, 40'h0, b};
      lat = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge CLK);
         tohost_we = 1'b0;
         if (fromhost_we) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic strobe(input logic [63:0] w);
      @(negedge CLK);
      tohost_we = 1'b1;
      tohost = w;
      @(negedge CLK);
      tohost_we = 1'b0;
   endtask

   function automatic logic [7:0] got_at(input int i);
      if (i < got_q.size()) return got_q[i];
      return 8'hxx;
   endfunction

   initial begin
      logic [7:0] str [3];
      int lat;

      str[0] = 8'h4F; str[1] = 8'h4B; str[2] = 8'h0A;
      RST = 1'b1; tohost_we = 1'b0; tohost = '0; con_ready = 1'b0;
      repeat (2) @(negedge CLK);
      check("rst_done", 64'(done), 64'd0);
      check("rst_pass", 64'(pass), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_exit_code", 64'(exit_code), 64'd0);
      check("rst_con_valid", 64'(con_valid), 64'd0);
      check("rst_fromhost_we", 64'(fromhost_we), 64'd0);
      check("rst_fromhost", fromhost, 64'd0);
      RST = 1'b0;

      // Console string, one write per ack.
      con_ready = 1'b1; ack_cnt = 0; got_q.delete();
      for (int i = 0; i < 3; i++) begin
         send_con(str[i], 10, lat);
         check($sformatf("str_lat%0d", i), 64'(lat), 64'd3);
         check($sformatf("str_ack_word%0d", i), fromhost, ACK_WORD);
      end
      repeat (4) @(negedge CLK);
      check("str_count", 64'(got_q.size()), 64'd3);
      for (int i = 0; i < 3; i++) check($sformatf("str_byte%0d", i), 64'(got_at(i)), 64'(str[i]));
      check("str_ack_held", fromhost, ACK_WORD);
      check("str_acks", 64'(ack_cnt), 64'd3);
      check("str_err", 64'(err), 64'd0);

      // Back-pressure: 16 fit, the 17th stalls until the sink drains.
      con_ready = 1'b0; ack_cnt = 0; got_q.delete();
      for (int i = 0; i < 16; i++) begin
         send_con(8'(8'hA0 + i), 10, lat);
         check($sformatf("bp_lat%0d", i), 64'(lat), 64'd3);
      end
      send_con(8'hB0, 20, lat);
      check("bp_stall_acks", 64'(ack_cnt), 64'd16);
      check("bp_con_valid", 64'(con_valid), 64'd1);
      check("bp_head", 64'(con_data), 64'hA0);
      con_ready = 1'b1;
      for (int i = 0; i < 20 && ack_cnt < 17; i++) @(negedge CLK);
      check("bp_ack17", 64'(ack_cnt), 64'd17);
      repeat (25) @(negedge CLK);
      check("bp_count", 64'(got_q.size()), 64'd17);
      for (int i = 0; i < 16; i++) check($sformatf("bp_byte%0d", i), 64'(got_at(i)), 64'(8'hA0 + i));
      check("bp_byte16", 64'(got_at(16)), 64'hB0);
      check("bp_empty", 64'(con_valid), 64'd0);

      // Strobe while in PUSH is an error; only the first byte goes through.
      ack_cnt = 0; got_q.delete();
      @(negedge CLK); tohost_we = 1'b1; tohost = 64'h0101_0000_0000_0055;
      @(negedge CLK); tohost_we = 1'b1; tohost = 64'h0101_0000_0000_0066;
      @(negedge CLK); tohost_we = 1'b0;
      repeat (8) @(negedge CLK);
      check("perr_err", 64'(err), 64'd1);
      check("perr_acks", 64'(ack_cnt), 64'd1);
      check("perr_count", 64'(got_q.size()), 64'd1);
      check("perr_byte", 64'(got_at(0)), 64'h55);

      // Unknown device in IDLE.
      do_reset();
      check("perr_rst_err", 64'(err), 64'd0);
      ack_cnt = 0;
      strobe(64'h0200_0000_0000_0000);
      repeat (6) @(negedge CLK);
      check("baddev_err", 64'(err), 64'd1);
      check("baddev_acks", 64'(ack_cnt), 64'd0);

      // Device 0 with payload[0]=0 is not an exit.
      do_reset();
      strobe(64'h0000_0000_0000_0002);
      check("noexit_err", 64'(err), 64'd1);
      check("noexit_done", 64'(done), 64'd0);

      // Reset while an ack countdown is pending with 3 bytes buffered.
      do_reset();
      con_ready = 1'b0; ack_cnt = 0; got_q.delete();
      for (int i = 0; i < 3; i++) begin
         send_con(8'(8'h31 + i), 10, lat);
         check($sformatf("mid_lat%0d", i), 64'(lat), 64'd3);
      end
      @(negedge CLK); tohost_we = 1'b1; tohost = 64'h0101_0000_0000_0034;
      @(negedge CLK); tohost_we = 1'b0;
      @(negedge CLK); RST = 1'b1;
      @(negedge CLK);
      check("mid_con_valid", 64'(con_valid), 64'd0);
      check("mid_fromhost_we", 64'(fromhost_we), 64'd0);
      check("mid_err", 64'(err), 64'd0);
      check("mid_done", 64'(done), 64'd0);
      RST = 1'b0;
      @(negedge CLK);
      check("mid_acks", 64'(ack_cnt), 64'd3);
      con_ready = 1'b1; got_q.delete();
      send_con(8'h77, 10, lat);
      check("mid_after_lat", 64'(lat), 64'd3);
      repeat (4) @(negedge CLK);
      check("mid_after_count", 64'(got_q.size()), 64'd1);
      check("mid_after_byte", 64'(got_at(0)), 64'h77);

      // Exit pass, then everything is ignored.
      do_reset();
      con_ready = 1'b1; ack_cnt = 0;
      strobe(64'h0000_0000_0000_0001);
      check("xpass_done", 64'(done), 64'd1);
      check("xpass_pass", 64'(pass), 64'd1);
      check("xpass_code", 64'(exit_code), 64'd0);
      strobe(64'h0101_0000_0000_0041);
      strobe(64'h0200_0000_0000_0000);
      repeat (6) @(negedge CLK);
      check("halt_done", 64'(done), 64'd1);
      check("halt_pass", 64'(pass), 64'd1);
      check("halt_err", 64'(err), 64'd0);
      check("halt_acks", 64'(ack_cnt), 64'd0);
      check("halt_con_valid", 64'(con_valid), 64'd0);

      // Exit fail with a byte still buffered; it drains in HALT.
      do_reset();
      con_ready = 1'b0; got_q.delete();
      send_con(8'h5A, 10, lat);
      check("xfail_con_lat", 64'(lat), 64'd3);
      strobe(64'h0000_0000_0000_0007);
      check("xfail_done", 64'(done), 64'd1);
      check("xfail_pass", 64'(pass), 64'd0);
      check("xfail_code", 64'(exit_code), 64'd3);
      check("xfail_pending", 64'(con_valid), 64'd1);
      con_ready = 1'b1;
      repeat (3) @(negedge CLK);
      check("xfail_drain_count", 64'(got_q.size()), 64'd1);
      check("xfail_drain_byte", 64'(got_at(0)), 64'h5A);
      check("xfail_drain_empty", 64'(con_valid), 64'd0);

      // Widest exit code.
      do_reset();
      strobe(64'h0000_FFFF_FFFF_FFFF);
      check("xmax_pass", 64'(pass), 64'd0);
      check("xmax_code", 64'(exit_code), 64'h0000_7FFF_FFFF_FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
